// File: rtl/core_pkg.sv
// Shared types for the core sequencer: run modes, pipeline stages
// and the reset pc default.
package core_pkg;

    typedef enum logic [2:0] {
        M_IDLE = 3'd0,
        M_LOAD = 3'd1,
        M_RUN  = 3'd2,
        M_HALT = 3'd3,
        M_DONE = 3'd4
    } mode_t;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } stage_t;

    localparam int unsigned N_STAGES = 5;
    localparam int unsigned N_MODES  = 5;
    localparam logic [63:0] RESET_PC_DEF = 64'h0;

endpackage

// File: rtl/core_sequencer_if.sv
// Control bundle between the sequencer (master) and the
// datapath / boot loader side (slave).
interface core_sequencer_if
    import core_pkg::*;
#(
    parameter int PC_W   = 32,
    parameter int WAIT_W = 5
);
    logic              boot_req;
    logic              load_done;
    logic              boot_ack;
    logic [PC_W-1:0]   npc_in;
    logic [WAIT_W-1:0] wait_time;
    logic              is_mem;
    logic              io_busy;
    logic              mem_ready;
    logic              stop_in;
    logic              halt_req;
    logic              step;
    logic [PC_W-1:0]   pc;
    logic              fd_en;
    logic              de_en;
    logic              ew_en;
    logic              e_start;
    logic              mem_req;
    logic              reg_we;
    mode_t             mode;
    stage_t            stage;
    logic              timeout;

    modport master (
        input  boot_req, load_done, boot_ack,
        input  npc_in, wait_time, is_mem,
        input  io_busy, mem_ready, stop_in,
        input  halt_req, step,
        output pc, fd_en, de_en, ew_en,
        output e_start, mem_req, reg_we,
        output mode, stage, timeout
    );

    modport slave (
        output boot_req, load_done, boot_ack,
        output npc_in, wait_time, is_mem,
        output io_busy, mem_ready, stop_in,
        output halt_req, step,
        input  pc, fd_en, de_en, ew_en,
        input  e_start, mem_req, reg_we,
        input  mode, stage, timeout
    );
endinterface

// File: rtl/core_sequencer_watchdog.sv
// Execute watchdog: counts busy cycles, flags a sticky timeout
// on the cycle the count would reach all-ones.
module seq_watchdog #(
    parameter int W = 16
) (
    input  logic clk,
    input  logic rstn,
    input  logic clr,
    input  logic en,
    output logic hit,
    output logic timeout
);
    localparam logic [W-1:0] LAST = {{(W-1){1'b1}}, 1'b0};

    logic [W-1:0] cnt;

    assign hit = en && !clr && (cnt == LAST);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt     <= '0;
            timeout <= 1'b0;
        end else begin
            timeout <= timeout | hit;
            if (clr)
                cnt <= '0;
            else if (en)
                cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: rtl/core_sequencer.sv
// Top-level core sequencer: boot handshake, stage FSM, pc,
// stage enables, debug halt/step and execute watchdog.
module core_sequencer
    import core_pkg::*;
#(
    parameter int PC_W   = 32,
    parameter int WAIT_W = 5,
    parameter int WDOG_W = 16,
    parameter logic [PC_W-1:0] RESET_PC = PC_W'(RESET_PC_DEF)
) (
    input  logic             clk,
    input  logic             rstn,
    core_sequencer_if.master bus
);
    mode_t             mode_q, mode_d;
    stage_t            stage_q, stage_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [WAIT_W-1:0] lat_q, lat_d;
    logic              step_q, step_d;
    logic              est_q, est_d;
    logic              run, ex_done, mem_done;
    logic              wd_en, wd_clr, wd_hit, wd_to;

    assign run      = (mode_q == M_RUN);
    assign ex_done  = run && (stage_q == S_EXEC) &&
                      (lat_q >= bus.wait_time) && !bus.io_busy;
    assign mem_done = run && (stage_q == S_MEM) && bus.mem_ready;
    assign wd_en    = run && (stage_q == S_EXEC || stage_q == S_MEM);
    assign wd_clr   = !wd_en || ex_done || mem_done;

    seq_watchdog #(.W(WDOG_W)) u_wdog (
        .clk     (clk),
        .rstn    (rstn),
        .clr     (wd_clr),
        .en      (wd_en),
        .hit     (wd_hit),
        .timeout (wd_to)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mode_q  <= M_IDLE;
            stage_q <= S_FETCH;
            pc_q    <= RESET_PC;
            lat_q   <= '0;
            step_q  <= 1'b0;
            est_q   <= 1'b0;
        end else begin
            mode_q  <= mode_d;
            stage_q <= stage_d;
            pc_q    <= pc_d;
            lat_q   <= lat_d;
            step_q  <= step_d;
            est_q   <= est_d;
        end
    end

    always_comb begin
        mode_d      = mode_q;
        stage_d     = stage_q;
        pc_d        = pc_q;
        lat_d       = lat_q;
        step_d      = step_q;
        est_d       = 1'b0;
        bus.fd_en   = 1'b0;
        bus.de_en   = 1'b0;
        bus.ew_en   = 1'b0;
        bus.mem_req = 1'b0;
        bus.reg_we  = 1'b0;
        unique case (mode_q)
            M_IDLE: if (bus.boot_req) mode_d = M_LOAD;
            M_LOAD: begin
                if (bus.load_done && bus.boot_ack) begin
                    mode_d  = M_RUN;
                    stage_d = S_FETCH;
                end
            end
            M_RUN: begin
                unique case (stage_q)
                    S_FETCH: begin
                        bus.fd_en = 1'b1;
                        stage_d   = S_DECODE;
                    end
                    S_DECODE: begin
                        bus.de_en = 1'b1;
                        pc_d      = bus.npc_in;
                        est_d     = 1'b1;
                        stage_d   = S_EXEC;
                    end
                    S_EXEC: begin
                        if (lat_q < bus.wait_time)
                            lat_d = lat_q + 1'b1;
                        if (ex_done) begin
                            lat_d = '0;
                            if (bus.is_mem) begin
                                stage_d = S_MEM;
                            end else begin
                                bus.ew_en = 1'b1;
                                stage_d   = S_WB;
                            end
                        end
                    end
                    S_MEM: begin
                        bus.mem_req = 1'b1;
                        if (mem_done) begin
                            bus.ew_en = 1'b1;
                            stage_d   = S_WB;
                        end
                    end
                    S_WB: begin
                        bus.reg_we = 1'b1;
                        stage_d    = S_FETCH;
                        step_d     = 1'b0;
                        if (bus.stop_in)
                            mode_d = M_DONE;
                        else if (bus.halt_req || step_q)
                            mode_d = M_HALT;
                    end
                    default: stage_d = S_FETCH;
                endcase
            end
            M_HALT: begin
                stage_d = S_FETCH;
                // a step pulse beats a simultaneous halt_req release
                if (bus.step) begin
                    mode_d = M_RUN;
                    step_d = 1'b1;
                end else if (!bus.halt_req) begin
                    mode_d = M_RUN;
                end
            end
            M_DONE: ;
            default: mode_d = M_IDLE;
        endcase
        if (wd_hit) begin
            mode_d  = M_HALT;
            stage_d = S_FETCH;
            lat_d   = '0;
            step_d  = 1'b0;
        end
    end

    assign bus.pc      = pc_q;
    assign bus.e_start = est_q;
    assign bus.mode    = mode_q;
    assign bus.stage   = stage_q;
    assign bus.timeout = wd_to;
endmodule
